// File: rtl/ram_program_loader.sv
// rtl/ram_program_loader.sv - host-to-RAM program loader that hands the RAM bus to the CU once a load session ends
module ram_program_loader #(
  parameter int adlines      = 8,
  parameter int datalines    = 16,
  parameter int WRITE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [adlines-1:0]   base_addr,
  input  logic                 in_valid,
  input  logic [datalines-1:0] in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [adlines-1:0]   cu_addressbus,
  input  logic [datalines-1:0] cu_toram,
  input  logic                 cu_read,
  input  logic                 cu_write,
  output logic [adlines-1:0]   ram_address,
  output logic [datalines-1:0] ram_datain,
  output logic                 ram_read,
  output logic                 ram_write,
  output logic                 cu_enable,
  output logic [adlines:0]     load_count,
  output logic                 load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_GAP,
    S_RUN,
    S_ERROR
  } state_t;

  localparam logic [3:0]         WC_LAST = 4'(WRITE_CYCLES - 1);
  localparam logic [adlines-1:0] PTR_MAX = '1;
  localparam logic [adlines-1:0] PTR_ONE = adlines'(1);
  localparam logic [adlines:0]   CNT_ONE = (adlines + 1)'(1);

  state_t               state_q, state_d;
  logic [adlines-1:0]   ptr_q, ptr_d;
  logic [datalines-1:0] data_q, data_d;
  logic                 last_q, last_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [adlines:0]     load_count_q, load_count_d;
  logic                 load_err_q, load_err_d;
  logic                 cu_enable_q, cu_enable_d;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    data_d       = data_q;
    last_d       = last_q;
    wcnt_d       = wcnt_q;
    load_count_d = load_count_q;
    load_err_d   = load_err_q;
    cu_enable_d  = cu_enable_q;

    // A new session wins over anything else, including a word offered in ACCEPT.
    if (load_start) begin
      ptr_d        = base_addr;
      load_count_d = '0;
      load_err_d   = 1'b0;
      cu_enable_d  = 1'b0;
      wcnt_d       = '0;
      state_d      = S_ACCEPT;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (in_valid) begin
            data_d  = in_data;
            last_d  = in_last;
            wcnt_d  = '0;
            state_d = S_WRITE;
          end
        end
        S_WRITE: begin
          if (wcnt_q == WC_LAST) begin
            state_d = S_GAP;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
        S_GAP: begin
          load_count_d = load_count_q + CNT_ONE;
          if (last_q) begin
            cu_enable_d = 1'b1;
            state_d     = S_RUN;
          end else if (ptr_q == PTR_MAX) begin
            load_err_d = 1'b1;
            state_d    = S_ERROR;
          end else begin
            ptr_d   = ptr_q + PTR_ONE;
            state_d = S_ACCEPT;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      wcnt_q       <= '0;
      load_count_q <= '0;
      load_err_q   <= 1'b0;
      cu_enable_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      data_q       <= data_d;
      last_q       <= last_d;
      wcnt_q       <= wcnt_d;
      load_count_q <= load_count_d;
      load_err_q   <= load_err_d;
      cu_enable_q  <= cu_enable_d;
    end
  end

  // RAM-side bus decodes straight from the registered state so reset drops the strobe without a clock.
  always_comb begin
    ram_address = '0;
    ram_datain  = '0;
    ram_read    = 1'b0;
    ram_write   = 1'b0;
    case (state_q)
      S_WRITE: begin
        ram_address = ptr_q;
        ram_datain  = data_q;
        ram_write   = 1'b1;
      end
      S_GAP: begin
        ram_address = ptr_q;
        ram_datain  = data_q;
      end
      S_RUN: begin
        ram_address = cu_addressbus;
        ram_datain  = cu_toram;
        ram_read    = cu_read;
        ram_write   = cu_write;
      end
      default: begin
      end
    endcase
  end

  assign in_ready   = (state_q == S_ACCEPT) && !load_start;
  assign cu_enable  = cu_enable_q;
  assign load_count = load_count_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// tb/tb_ram_program_loader.sv - self-checking bench: directed session table, corner sequences, random sessions vs a session model
module tb_ram_program_loader;

  localparam int WC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  cu_addressbus = '0;
  logic [15:0] cu_toram = '0;
  logic        cu_read = 1'b0;
  logic        cu_write = 1'b0;
  logic [7:0]  ram_address;
  logic [15:0] ram_datain;
  logic        ram_read;
  logic        ram_write;
  logic        cu_enable;
  logic [8:0]  load_count;
  logic        load_err;

  ram_program_loader #(.adlines(8), .datalines(16), .WRITE_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .cu_addressbus(cu_addressbus), .cu_toram(cu_toram), .cu_read(cu_read), .cu_write(cu_write),
    .ram_address(ram_address), .ram_datain(ram_datain), .ram_read(ram_read), .ram_write(ram_write),
    .cu_enable(cu_enable), .load_count(load_count), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       base;
    logic [3:0][15:0] w;
    logic [2:0]       n;
    logic             last;
    logic [3:0]       stall;
    logic [8:0]       exp_count;
    logic             exp_err;
    logic             exp_en;
  } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          wr_hi = 0;
  int          viol = 0;
  bit          noise = 1'b0;
  bit          mem_init = 1'b1;
  logic [15:0] mem [256];
  logic [15:0] exp_mem [256];
  vec_t        tbl [5];

  // Behavioural RAM behind the loader.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
    end else if (ram_write) begin
      mem[ram_address] <= ram_datain;
    end
  end

  always @(negedge clk) begin
    if (ram_write) wr_hi <= wr_hi + 1;
    if (!cu_enable && ram_read) viol <= viol + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (noise) begin
      cu_addressbus = 8'($urandom);
      cu_toram      = 16'($urandom);
      cu_read       = 1'($urandom);
      cu_write      = 1'($urandom);
    end
  endtask

  task automatic cu_quiet();
    noise = 1'b0;
    cu_addressbus = '0;
    cu_toram = '0;
    cu_read = 1'b0;
    cu_write = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] b);
    load_start = 1'b1;
    base_addr = b;
    step();
    load_start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    #1;
    while (in_ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) check("accept_timeout", 0, 1);
    step();
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
  endtask

  task automatic run_session(input logic [7:0] base, input logic [3:0][15:0] w, input int k,
                             input int stall, input bit run, input bit err);
    int          wr0;
    logic [7:0]  a;
    wr0 = wr_hi;
    pulse_start(base);
    noise = 1'b1;
    for (int i = 0; i < k; i++) begin
      repeat (stall) step();
      send_word(w[i], run && (i == k - 1));
    end
    cu_quiet();
    if (run) begin
      repeat (WC + 1) begin
        check("cu_enable_early", 32'(cu_enable), 0);
        step();
      end
      check("cu_enable_rise", 32'(cu_enable), 1);
    end else if (err) begin
      in_valid = 1'b1;
      in_data = 16'hFFFF;
      repeat (WC + 1) step();
      check("err_in_ready", 32'(in_ready), 0);
      in_valid = 1'b0;
      in_data = '0;
    end else begin
      repeat (WC + 1) step();
      check("pending_in_ready", 32'(in_ready), 1);
    end
    check("load_count", 32'(load_count), 32'(k));
    check("load_err", 32'(load_err), 32'(err));
    check("cu_enable", 32'(cu_enable), 32'(run));
    check("write_cycles", 32'(wr_hi - wr0), 32'(k * WC));
    for (int i = 0; i < k; i++) begin
      a = 8'(int'(base) + i);
      exp_mem[a] = w[i];
      check("ram_word", 32'(mem[a]), 32'(exp_mem[a]));
    end
    if (err) begin
      a = 8'(int'(base) + k);
      check("no_wrap_write", 32'(mem[a]), 32'(exp_mem[a]));
    end
  endtask

  function automatic vec_t mk(logic [7:0] b, logic [63:0] w, int n, bit l, int st, int c, bit e, bit en);
    vec_t v;
    v.base = b; v.w = w; v.n = 3'(n); v.last = l; v.stall = 4'(st);
    v.exp_count = 9'(c); v.exp_err = e; v.exp_en = en;
    return v;
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][15:0] rw;
    logic [7:0]       rb;
    int               rn, rk;
    bit               rl, rrun, rerr;

    for (int i = 0; i < 256; i++) exp_mem[i] = 16'hC000 | 16'(i);
    tbl[0] = mk(8'd1,   {16'h0, 16'h0000, 16'h018E, 16'h0086}, 3, 1, 0, 3, 0, 1);
    tbl[1] = mk(8'd16,  {16'h0, 16'h0,    16'h0002, 16'h0005}, 2, 1, 3, 2, 0, 1);
    tbl[2] = mk(8'd255, {16'h0, 16'h0,    16'h5A5A, 16'hA5A5}, 2, 0, 0, 1, 1, 0);
    tbl[3] = mk(8'd253, {16'h0, 16'h0003, 16'h0002, 16'h0001}, 3, 1, 1, 3, 0, 1);
    tbl[4] = mk(8'd254, {16'h0, 16'h0009, 16'h0008, 16'h0007}, 3, 1, 0, 2, 1, 0);

    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_ram_write", 32'(ram_write), 0);
    check("rst_ram_read", 32'(ram_read), 0);
    check("rst_ram_address", 32'(ram_address), 0);
    check("rst_ram_datain", 32'(ram_datain), 0);
    check("rst_cu_enable", 32'(cu_enable), 0);
    check("rst_load_count", 32'(load_count), 0);
    check("rst_load_err", 32'(load_err), 0);
    mem_init = 1'b0;
    rst_n = 1'b1;

    in_valid = 1'b1;
    in_data = 16'h1111;
    cu_write = 1'b1;
    repeat (3) step();
    check("idle_in_ready", 32'(in_ready), 0);
    check("idle_ram_write", 32'(ram_write), 0);
    in_valid = 1'b0;
    cu_quiet();

    foreach (tbl[t]) begin
      run_session(tbl[t].base, tbl[t].w, int'(tbl[t].exp_count), int'(tbl[t].stall),
                  tbl[t].exp_en, tbl[t].exp_err);
    end

    // Reset in the second write cycle.
    pulse_start(8'd1);
    send_word(16'h0086, 1'b0);
    step();
    check("mid_write_strobe", 32'(ram_write), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_ram_write", 32'(ram_write), 0);
    check("async_ram_address", 32'(ram_address), 0);
    check("async_ram_datain", 32'(ram_datain), 0);
    check("async_in_ready", 32'(in_ready), 0);
    check("async_load_count", 32'(load_count), 0);
    check("async_cu_enable", 32'(cu_enable), 0);
    exp_mem[1] = 16'h0086;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    check("post_rst_idle", 32'(in_ready), 0);
    run_session(tbl[0].base, tbl[0].w, 3, 0, 1, 0);

    // CU passthrough in RUN, then restart cuts it off.
    cu_addressbus = 8'h33; cu_toram = 16'h1234; cu_read = 1'b1;
    #1;
    check("pass_address", 32'(ram_address), 32'h33);
    check("pass_datain", 32'(ram_datain), 32'h1234);
    check("pass_read", 32'(ram_read), 1);
    cu_quiet();
    pulse_start(8'd4);
    check("restart_cu_enable", 32'(cu_enable), 0);
    cu_write = 1'b1; cu_read = 1'b1; cu_addressbus = 8'h44;
    #1;
    check("restart_no_write", 32'(ram_write), 0);
    check("restart_no_read", 32'(ram_read), 0);
    cu_quiet();
    send_word(16'h4444, 1'b1);
    repeat (WC + 1) step();
    exp_mem[4] = 16'h4444;
    check("restart_cu_enable_again", 32'(cu_enable), 1);
    check("restart_count", 32'(load_count), 1);
    check("restart_word", 32'(mem[4]), 32'(exp_mem[4]));

    // load_start together with an offered word in ACCEPT.
    pulse_start(8'd10);
    load_start = 1'b1; base_addr = 8'd20;
    in_valid = 1'b1; in_data = 16'hBEEF; in_last = 1'b1;
    #1;
    check("collide_in_ready", 32'(in_ready), 0);
    step();
    load_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    #1;
    check("collide_count", 32'(load_count), 0);
    check("collide_no_write", 32'(ram_write), 0);
    check("collide_ready", 32'(in_ready), 1);
    send_word(16'h2020, 1'b1);
    repeat (WC + 1) step();
    exp_mem[20] = 16'h2020;
    check("collide_word", 32'(mem[20]), 32'(exp_mem[20]));
    check("collide_old_base", 32'(mem[10]), 32'(exp_mem[10]));
    check("collide_count_after", 32'(load_count), 1);

    // load_start during WRITE aborts the strobe.
    pulse_start(8'd30);
    send_word(16'h3030, 1'b1);
    check("abort_strobe_on", 32'(ram_write), 1);
    pulse_start(8'd40);
    exp_mem[30] = 16'h3030;
    check("abort_strobe_off", 32'(ram_write), 0);
    check("abort_count", 32'(load_count), 0);
    send_word(16'h4040, 1'b1);
    repeat (WC + 1) step();
    exp_mem[40] = 16'h4040;
    check("abort_next_word", 32'(mem[40]), 32'(exp_mem[40]));
    check("abort_next_count", 32'(load_count), 1);

    // Random sessions; the model only knows where words land and when the address space runs out.
    for (int s = 0; s < 12; s++) begin
      rb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 255));
      rn = $urandom_range(1, 4);
      rl = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) rw[i] = 16'($urandom);
      rk = (rn < 256 - int'(rb)) ? rn : 256 - int'(rb);
      rrun = (rk == rn) && rl;
      rerr = !rrun && (int'(rb) + rk - 1 == 255);
      run_session(rb, rw, rk, $urandom_range(0, 2), rrun, rerr);
    end

    check("read_while_loading", 32'(viol), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_program_loader.md
RAM_PROGRAM_LOADER -- requirements
Module: ram_program_loader

Interface
REQ-001 Parameter adlines, default 8: RAM address width.
REQ-002 Parameter datalines, default 16: RAM data width.
REQ-003 Parameter WRITE_CYCLES, default 2: write-strobe length in cycles per word, legal range 1-15.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 load_start  in  1  one-cycle pulse that begins a load session.
REQ-007 base_addr  in  adlines  first RAM address of the session; sampled on load_start.
REQ-008 in_valid  in  1  host word valid.
REQ-009 in_data  in  datalines  host word.
REQ-010 in_last  in  1  marks the final word of the session; qualified by in_valid.
REQ-011 in_ready  out  1  loader accepts a word this cycle.
REQ-012 cu_addressbus / cu_toram / cu_read / cu_write  in  adlines / datalines / 1 / 1  CU-side RAM bus.
REQ-013 ram_address / ram_datain / ram_read / ram_write  out  adlines / datalines / 1 / 1  RAM-side bus.
REQ-014 cu_enable  out  1  run enable to the control unit.
REQ-015 load_count  out  adlines+1  words written in the current session.
REQ-016 load_err  out  1  address overflow in the current session.

Function
REQ-017 States SHALL be IDLE, ACCEPT, WRITE, GAP, RUN, ERROR.
REQ-018 IDLE: in_ready=0, cu_enable=0, all RAM-side outputs 0; load_start moves to ACCEPT.
REQ-019 On load_start in any state: ptr<=base_addr, load_count<=0, load_err<=0, cu_enable<=0, next state ACCEPT. load_start takes priority over every other event in the same cycle.
REQ-020 ACCEPT: in_ready=1 combinationally. On in_valid&in_ready, in_data and in_last are captured and the state moves to WRITE.
REQ-021 WRITE: ram_address=ptr, ram_datain=captured word, ram_write=1, ram_read=0 for exactly WRITE_CYCLES cycles; in_ready=0.
REQ-022 GAP: one cycle with ram_write=0 and address/data held. At the end of GAP, load_count is incremented.
REQ-023 GAP exit, captured last=1: go to RUN.
REQ-024 GAP exit, last=0 and ptr != 2^adlines-1: ptr<=ptr+1 and go to ACCEPT.
REQ-025 GAP exit, last=0 and ptr == 2^adlines-1: go to ERROR and set load_err=1. No wrap-around write occurs.
REQ-026 Per-word latency: 1 accept cycle + WRITE_CYCLES + 1 gap cycle; maximum throughput is 1 word per WRITE_CYCLES+2 cycles.
REQ-027 RUN: cu_enable=1 (registered, first asserted in the cycle after GAP exit). The ram_* outputs pass the cu_* inputs through combinationally; in_ready=0.
REQ-028 The cu_* inputs SHALL be ignored in every state except RUN.
REQ-029 ERROR: cu_enable=0, in_ready=0, RAM-side outputs 0, load_err held. Only load_start or reset leaves ERROR.
REQ-030 load_start during WRITE/GAP: the current write strobe is aborted immediately (ram_write=0 next cycle); the partial word counts as not written.
REQ-031 in_valid in any state other than ACCEPT SHALL be ignored and not consumed.
REQ-032 ram_write and ram_read SHALL never both be 1 while the loader owns the bus.
REQ-033 load_count and ptr SHALL hold their values in RUN and ERROR until the next load_start.

Reset
REQ-034 rst_n low: state=IDLE, ptr=0, load_count=0, load_err=0, cu_enable=0, in_ready=0, ram_write=0, ram_read=0, ram_address=0, ram_datain=0. This takes effect immediately, without a clock edge.
REQ-035 Reset asserted mid-WRITE drops ram_write asynchronously. After rst_n rises, the loader stays in IDLE until load_start.

Verification
REQ-036 Program load: base_addr=1; words 0x0086, 0x018E, 0x0000 (last on third) -> RAM[1..3] hold those values, load_count=3, cu_enable rises 1 cycle after the third GAP, load_err=0.
REQ-037 Data load with host stalls: base_addr=16; words 5, 2 with in_valid low 3 cycles between -> RAM[16]=5, RAM[17]=2. ram_write is high exactly 2 cycles per word with WRITE_CYCLES=2.
REQ-038 Overflow: base_addr=255 (adlines=8); two words, neither last -> RAM[255] is written, the state goes to ERROR, load_err=1, load_count=1, RAM[0] is unchanged, cu_enable=0.
REQ-039 Restart while running: after REQ-036, pulse load_start with base_addr=4 -> cu_enable falls the next cycle and CU bus activity no longer reaches the RAM. After loading 1 word (last), cu_enable=1 again and load_count=1.
REQ-040 Async reset mid-write: assert rst_n low in the second WRITE cycle -> ram_write=0 without a clock edge and all outputs are at their reset values. After release and a new load, the behaviour is as in REQ-036.
REQ-041 Simultaneous load_start and in_valid in ACCEPT: the word is not consumed, ptr=new base_addr, load_count=0.
